tcp_segment_tx: RTL

Streaming TCP segment transmitter, the byte-stream successor to the fixed-width TCP encoder in the network path. It accepts a per-segment command and a variable-length payload byte stream, buffers the payload, and computes the TCP checksum incrementally. It tracks the sending sequence number across segments and emits the 20-byte header followed by the payload as a byte stream with valid/ready backpressure toward the IP layer.

---
 rtl/tcp_segment_tx.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/tcp_segment_tx.sv
// Streaming TCP segment transmitter: per-segment command plus payload byte
// stream in, 20-byte header followed by payload out, checksum built up as
// the payload arrives and sequence number carried across segments.
//
// Handshakes: every stream (cmd, s, m) transfers on a rising edge where
// valid && ready are both high. A source holds valid and its data stable
// until that transfer; ready never depends on valid.
module tcp_segment_tx #(
  parameter int          MAX_PAYLOAD = 262,
  parameter logic [15:0] SRC_PORT    = 16'd1024,
  parameter logic [15:0] DST_PORT    = 16'd9000,
  parameter logic [31:0] SRC_ADDR    = 32'h7f000001,
  parameter logic [31:0] DST_ADDR    = 32'h7f000001,
  parameter logic [15:0] WINDOW      = 16'd302,
  parameter logic [31:0] ISN         = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_flags,
  input  logic [31:0] cmd_ack_num,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_data,
  output logic        m_last,
  output logic [31:0] seq_num,
  output logic        done,
  output logic        trunc,
  output logic [2:0]  dbg_state
);

  localparam int CW = $clog2(MAX_PAYLOAD + 1);
  localparam int IW = (CW > 5) ? CW : 5;
  localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam logic [CW-1:0] MAX_C = CW'(MAX_PAYLOAD);

  typedef enum logic [2:0] {IDLE, LOAD, SUM, HDR, PAY} state_e;

  state_e        state_q, state_d;
  logic [5:0]    flags_q, flags_d;
  logic [31:0]   ack_q, ack_d;
  logic [31:0]   acc_q, acc_d;
  logic [31:0]   seq_q, seq_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    hi_q, hi_d;
  logic [15:0]   csum_q, csum_d;
  logic          done_q, done_d;
  logic          trunc_q, trunc_d;
  logic [7:0]    buf_q [MAX_PAYLOAD];
  logic          buf_we;

  logic          s_fire, m_fire, load_end;
  logic [CW-1:0] count_inc;
  logic [IW-1:0] count_ext;
  logic [31:0]   ack_sel, pre_sum, len_sum, seq_fin;
  logic [16:0]   fold1;
  logic [15:0]   fold2;
  logic [7:0]    hdr_byte;

  assign count_inc = count_q + CW'(1);
  assign count_ext = IW'(count_q);
  assign s_fire    = s_valid && s_ready;
  assign m_fire    = m_valid && m_ready;
  assign load_end  = s_last || (count_inc == MAX_C);

  // Header words known at command time: pseudo-header, ports, seq, ack,
  // offset/flags, window (urgent pointer is zero and contributes nothing).
  assign ack_sel = cmd_flags[4] ? cmd_ack_num : 32'd0;
  assign pre_sum = 32'(SRC_ADDR[31:16]) + 32'(SRC_ADDR[15:0])
                 + 32'(DST_ADDR[31:16]) + 32'(DST_ADDR[15:0]) + 32'd6
                 + 32'(SRC_PORT) + 32'(DST_PORT)
                 + 32'(seq_q[31:16]) + 32'(seq_q[15:0])
                 + 32'(ack_sel[31:16]) + 32'(ack_sel[15:0])
                 + 32'({4'd5, 6'd0, cmd_flags}) + 32'(WINDOW);

  // TCP length joins the sum last; two folds absorb every carry.
  assign len_sum = acc_q + {16'd0, 16'd20 + 16'(count_q)};
  assign fold1   = {1'b0, len_sum[15:0]} + {1'b0, len_sum[31:16]};
  assign fold2   = fold1[15:0] + {15'd0, fold1[16]};

  // SYN and FIN each occupy one sequence number.
  assign seq_fin = seq_q + 32'(count_q) + {31'd0, flags_q[1]} + {31'd0, flags_q[0]};

  assign cmd_ready = (state_q == IDLE);
  assign s_ready   = (state_q == LOAD) && (count_q < MAX_C);
  assign m_valid   = (state_q == HDR) || (state_q == PAY);
  assign m_last    = ((state_q == HDR) && (idx_q == IW'(19)) && (count_q == '0))
                  || ((state_q == PAY) && (idx_q == count_ext - IW'(1)));
  assign seq_num   = seq_q;
  assign done      = done_q;
  assign trunc     = trunc_q;
  assign dbg_state = state_q;

  // Header byte selection in network byte order.
  always_comb begin
    hdr_byte = 8'h00;
    case (idx_q[4:0])
      5'd0:  hdr_byte = SRC_PORT[15:8];
      5'd1:  hdr_byte = SRC_PORT[7:0];
      5'd2:  hdr_byte = DST_PORT[15:8];
      5'd3:  hdr_byte = DST_PORT[7:0];
      5'd4:  hdr_byte = seq_q[31:24];
      5'd5:  hdr_byte = seq_q[23:16];
      5'd6:  hdr_byte = seq_q[15:8];
      5'd7:  hdr_byte = seq_q[7:0];
      5'd8:  hdr_byte = ack_q[31:24];
      5'd9:  hdr_byte = ack_q[23:16];
      5'd10: hdr_byte = ack_q[15:8];
      5'd11: hdr_byte = ack_q[7:0];
      5'd12: hdr_byte = 8'h50;
      5'd13: hdr_byte = {2'b00, flags_q};
      5'd14: hdr_byte = WINDOW[15:8];
      5'd15: hdr_byte = WINDOW[7:0];
      5'd16: hdr_byte = csum_q[15:8];
      5'd17: hdr_byte = csum_q[7:0];
      default: hdr_byte = 8'h00;
    endcase
  end

  // Output byte: header, then buffered payload; zero when idle.
  always_comb begin
    m_data = 8'h00;
    if (state_q == HDR) m_data = hdr_byte;
    else if (state_q == PAY) m_data = buf_q[idx_q[AW-1:0]];
  end

  // Next-state and datapath update for the segment FSM.
  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    ack_d   = ack_q;
    acc_d   = acc_q;
    seq_d   = seq_q;
    count_d = count_q;
    idx_d   = idx_q;
    hi_d    = hi_q;
    csum_d  = csum_q;
    done_d  = 1'b0;
    trunc_d = 1'b0;
    buf_we  = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid) begin
        flags_d = cmd_flags;
        ack_d   = ack_sel;
        acc_d   = pre_sum;
        count_d = '0;
        idx_d   = '0;
        state_d = cmd_flags[3] ? LOAD : SUM;
      end
      LOAD: if (s_fire) begin
        buf_we  = 1'b1;
        count_d = count_inc;
        if (!count_q[0]) hi_d = s_data;
        else acc_d = acc_q + {16'd0, hi_q, s_data};
        if (load_end) begin
          // An odd-length payload pads its final byte with a zero low byte.
          if (!count_q[0]) acc_d = acc_q + {16'd0, s_data, 8'h00};
          trunc_d = !s_last;
          state_d = SUM;
        end
      end
      SUM: begin
        csum_d  = ~fold2;
        idx_d   = '0;
        state_d = HDR;
      end
      HDR: if (m_fire) begin
        if (idx_q == IW'(19)) begin
          idx_d = '0;
          if (count_q != '0) begin
            state_d = PAY;
          end else begin
            seq_d   = seq_fin;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      PAY: if (m_fire) begin
        if (m_last) begin
          seq_d   = seq_fin;
          done_d  = 1'b1;
          count_d = '0;
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      flags_q <= '0;
      ack_q   <= '0;
      acc_q   <= '0;
      seq_q   <= ISN;
      count_q <= '0;
      idx_q   <= '0;
      hi_q    <= '0;
      csum_q  <= '0;
      done_q  <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      ack_q   <= ack_d;
      acc_q   <= acc_d;
      seq_q   <= seq_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      hi_q    <= hi_d;
      csum_q  <= csum_d;
      done_q  <= done_d;
      trunc_q <= trunc_d;
    end
  end

  // Payload buffer write; contents need no reset since count gates reads.
  always_ff @(posedge clk) begin
    if (buf_we) buf_q[count_q[AW-1:0]] <= s_data;
  end

endmodule
